// File: rtl/reg_file.sv
// Eight-entry register file on a shared datapath bus, with a program-counter
// register that can self-increment and a sticky multi-driver conflict flag.
module reg_file #(
  parameter int                WIDTH    = 16,
  parameter int                PC_INDEX = 7,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       regOes,
  input  logic [7:0]       regNotLoads,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             pcInc,
  input  logic             clearConflict,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataOutValid,
  output logic [WIDTH-1:0] pc,
  output logic             busConflict
);

  logic [WIDTH-1:0] r_regs [8];
  logic             r_conflict;
  logic [3:0]       w_oe_count;
  logic [WIDTH-1:0] w_bus;

  always_comb begin
    w_oe_count = '0;
    w_bus      = '0;
    for (int i = 0; i < 8; i++) begin
      w_oe_count = w_oe_count + {3'b000, regOes[i]};
      if (regOes[i]) w_bus = w_bus | r_regs[i];
    end
  end

  // Load has priority over increment; only the PC entry ever increments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= (i == PC_INDEX) ? RESET_PC : '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (!regNotLoads[i]) begin
          r_regs[i] <= dataIn;
        end else if ((i == PC_INDEX) && pcInc) begin
          r_regs[i] <= r_regs[i] + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // A conflict seen on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conflict <= 1'b0;
    end else if (w_oe_count > 4'd1) begin
      r_conflict <= 1'b1;
    end else if (clearConflict) begin
      r_conflict <= 1'b0;
    end
  end

  assign dataOut      = w_bus;
  assign dataOutValid = (w_oe_count == 4'd1);
  assign pc           = r_regs[PC_INDEX];
  assign busConflict  = r_conflict;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed scenarios followed by random traffic, all checked
// against an array-based reference model of the register file.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic [7:0]  regOes;
  logic [7:0]  regNotLoads;
  logic [15:0] dataIn;
  logic        pcInc;
  logic        clearConflict;
  logic [15:0] dataOut;
  logic        dataOutValid;
  logic [15:0] pc;
  logic        busConflict;

  int tests;
  int fails;

  logic [15:0] m_regs [8];
  logic        m_conf;

  reg_file #(.WIDTH(16), .PC_INDEX(7), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .regOes       (regOes),
    .regNotLoads  (regNotLoads),
    .dataIn       (dataIn),
    .pcInc        (pcInc),
    .clearConflict(clearConflict),
    .dataOut      (dataOut),
    .dataOutValid (dataOutValid),
    .pc           (pc),
    .busConflict  (busConflict)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_conf = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected bus value and validity are recomputed from the model every time.
  task automatic check_all(input string tag);
    logic [15:0] exp_out;
    int          n;
    exp_out = 16'h0000;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (regOes[i]) begin
        exp_out = exp_out | m_regs[i];
        n++;
      end
    end
    chk({tag, ".dataOut"}, dataOut, exp_out);
    chk({tag, ".valid"}, {15'd0, dataOutValid}, {15'd0, (n == 1)});
    chk({tag, ".pc"}, pc, m_regs[7]);
    chk({tag, ".conflict"}, {15'd0, busConflict}, {15'd0, m_conf});
  endtask

  // One rising edge: model follows the inputs that are present at the edge.
  task automatic edge_step();
    logic [15:0] nxt [8];
    logic        nconf;
    int          n;
    n = 0;
    for (int i = 0; i < 8; i++) if (regOes[i]) n++;
    for (int i = 0; i < 8; i++) begin
      nxt[i] = m_regs[i];
      if (regNotLoads[i] == 1'b0) nxt[i] = dataIn;
      else if (i == 7 && pcInc) nxt[i] = m_regs[i] + 16'd1;
    end
    nconf = m_conf;
    if (n > 1) nconf = 1'b1;
    else if (clearConflict) nconf = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 8; i++) m_regs[i] = nxt[i];
    m_conf = nconf;
    #1;
  endtask

  task automatic idle_inputs();
    regOes = 8'h00; regNotLoads = 8'hFF; dataIn = 16'h0000;
    pcInc = 1'b0; clearConflict = 1'b0;
  endtask

  task automatic read_every_reg(input string tag);
    for (int i = 0; i < 8; i++) begin
      regOes = 8'(1 << i);
      #1;
      chk($sformatf("%s.r%0d", tag, i), dataOut, m_regs[i]);
    end
    regOes = 8'h00;
    #1;
  endtask

  task automatic load(input logic [7:0] mask, input logic [15:0] val);
    regNotLoads = ~mask; dataIn = val;
    edge_step();
    regNotLoads = 8'hFF;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    model_reset();
    reset = 1'b1;
    regOes = 8'h00; regNotLoads = 8'h00; dataIn = 16'hBEEF;
    pcInc = 1'b1; clearConflict = 1'b0;
    // 1: reset held across edges with every load and increment requested
    repeat (2) @(posedge clk);
    #2;
    check_all("rst");
    idle_inputs();
    reset = 1'b0;
    #1;
    read_every_reg("rst");

    // 2: single load then read it back
    load(8'h08, 16'h1234);
    regOes = 8'h08;
    #1;
    check_all("ld3");
    read_every_reg("ld3");

    // 3: PC wrap, increment, load beats increment
    load(8'h80, 16'hFFFF);
    pcInc = 1'b1;
    edge_step();
    chk("pc.wrap", pc, 16'h0000);
    edge_step();
    chk("pc.inc", pc, 16'h0001);
    regNotLoads = ~8'h80; dataIn = 16'h0100;
    edge_step();
    chk("pc.ldwin", pc, 16'h0100);
    pcInc = 1'b0; regNotLoads = 8'hFF;
    edge_step();
    chk("pc.hold", pc, 16'h0100);

    // 4: read during write shows old value until the edge
    regNotLoads = ~8'h06; dataIn = 16'hA5A5; regOes = 8'h02;
    #1;
    chk("rdw.old", dataOut, 16'h0000);
    edge_step();
    regNotLoads = 8'hFF;
    #1;
    chk("rdw.new", dataOut, 16'hA5A5);
    read_every_reg("rdw");

    // 5: conflict set, clear, and set-beats-clear
    regOes = 8'h03;
    #1;
    check_all("cf.pre");
    edge_step();
    chk("cf.set", {15'd0, busConflict}, 16'd1);
    regOes = 8'h00; clearConflict = 1'b1;
    edge_step();
    chk("cf.clr", {15'd0, busConflict}, 16'd0);
    regOes = 8'h03; clearConflict = 1'b0;
    edge_step();
    regOes = 8'h81; clearConflict = 1'b1;
    edge_step();
    chk("cf.setwin", {15'd0, busConflict}, 16'd1);

    // 6: no enable -> zero bus, flag unchanged
    regOes = 8'h00; clearConflict = 1'b0;
    #1;
    check_all("none");
    edge_step();
    check_all("none.hold");

    // random traffic
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 3))
        0: regOes = 8'h00;
        1, 2: regOes = 8'(1 << $urandom_range(0, 7));
        default: regOes = 8'($urandom);
      endcase
      regNotLoads = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      dataIn = 16'($urandom);
      if ($urandom_range(0, 9) == 0) dataIn = 16'hFFFF;
      pcInc = 1'($urandom);
      clearConflict = ($urandom_range(0, 3) == 0);
      #1;
      check_all("rnd.pre");
      edge_step();
      check_all("rnd.post");
    end

    // mid-cycle reset pulse with loads pending
    regNotLoads = 8'h00; dataIn = 16'hBEEF; pcInc = 1'b1; regOes = 8'h03;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("rst2.async");
    @(posedge clk);
    #2;
    idle_inputs();
    reset = 1'b0;
    #1;
    check_all("rst2");
    read_every_reg("rst2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
